// File: rtl/hft_msg_pkg.sv
// Shared order/message definitions for the ITCH-style parser and encoder.
// Optional feature macro: ITCH_MSG_CHECKSUM_EN (adds a 10th XOR checksum word).
package hft_msg_pkg;

    typedef enum logic [1:0] {
        ORD_ADD     = 2'd0,
        ORD_DELETE  = 2'd1,
        ORD_EXECUTE = 2'd2,
        ORD_ILLEGAL = 2'd3
    } order_t;

    typedef enum logic {
        TRADE_BUY  = 1'b0,
        TRADE_SELL = 1'b1
    } trade_t;

    typedef enum logic [1:0] {
        STK_AAPL  = 2'd0,
        STK_AMZN  = 2'd1,
        STK_GOOGL = 2'd2,
        STK_MSFT  = 2'd3
    } stock_t;

    localparam logic [7:0] MSG_TYPE_ADD     = 8'h41;  // 'A'
    localparam logic [7:0] MSG_TYPE_DELETE  = 8'h44;  // 'D'
    localparam logic [7:0] MSG_TYPE_EXECUTE = 8'h45;  // 'E'

    // 8-byte ASCII symbols, space padded
    localparam logic [63:0] STOCK_AAPL  = 64'h4141504C20202020;
    localparam logic [63:0] STOCK_AMZN  = 64'h414D5A4E20202020;
    localparam logic [63:0] STOCK_GOOGL = 64'h474F4F474C202020;
    localparam logic [63:0] STOCK_MSFT  = 64'h4D53465420202020;

    // Words produced by the field packer; the checksum word (if any) is extra
    localparam int PACK_WORDS = 9;

`ifdef ITCH_MSG_CHECKSUM_EN
    localparam int MSG_WORDS_DEF = 10;
`else
    localparam int MSG_WORDS_DEF = 9;
`endif

    function automatic logic [63:0] stock_ascii(input stock_t s);
        case (s)
            STK_AAPL:  return STOCK_AAPL;
            STK_AMZN:  return STOCK_AMZN;
            STK_GOOGL: return STOCK_GOOGL;
            default:   return STOCK_MSFT;
        endcase
    endfunction

    function automatic logic [7:0] msg_type_byte(input order_t t);
        case (t)
            ORD_ADD:     return MSG_TYPE_ADD;
            ORD_DELETE:  return MSG_TYPE_DELETE;
            ORD_EXECUTE: return MSG_TYPE_EXECUTE;
            default:     return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/itch_msg_pack.sv
// Combinational packer: decoded order fields -> 9 little-endian 32-bit frame words.
module itch_msg_pack
    import hft_msg_pkg::*;
(
    input  logic                         order_type_i,
    input  order_t                       type_i,
    input  stock_t                       stock_i,
    input  logic [63:0]                  order_id_i,
    input  logic [31:0]                  price_i,
    input  logic [31:0]                  quantity_i,
    input  trade_t                       side_i,
    input  logic [47:0]                  time_i,
    input  logic [15:0]                  locate_i,
    input  logic [15:0]                  tracking_i,
    output logic [PACK_WORDS-1:0][31:0]  words_o
);

    logic [63:0] stk;
    logic        unused_ok;

    assign stk       = stock_ascii(stock_i);
    assign unused_ok = order_type_i;

    // Common header fields first, then the type-specific tail starting at byte 19
    always_comb begin
        words_o        = '0;
        words_o[0]     = {tracking_i[7:0], locate_i, msg_type_byte(type_i)};
        words_o[1]     = {time_i[23:0], tracking_i[15:8]};
        words_o[2]     = {order_id_i[7:0], time_i[47:24]};
        words_o[3]     = order_id_i[39:8];
        words_o[4][23:0] = order_id_i[63:40];
        case (type_i)
            ORD_ADD: begin
                words_o[4][31:24] = {7'd0, side_i == TRADE_SELL};
                words_o[5]        = quantity_i;
                words_o[6]        = stk[31:0];
                words_o[7]        = stk[63:32];
                words_o[8]        = price_i;
            end
            ORD_DELETE: begin
                words_o[4][31:24] = stk[7:0];
                words_o[5]        = stk[39:8];
                words_o[6][23:0]  = stk[63:40];
            end
            ORD_EXECUTE: begin
                words_o[4][31:24] = quantity_i[7:0];
                words_o[5]        = {stk[7:0], quantity_i[31:8]};
                words_o[6]        = stk[39:8];
                words_o[7][23:0]  = stk[63:40];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/itch_msg_encoder.sv
// ITCH-style order encoder: accepts one order, streams its frame one word per cycle.
// Optional feature macro: ITCH_MSG_CHECKSUM_EN (XOR checksum appended as word 9;
// MSG_WORDS must then be 10, which is the package default under that macro).
module itch_msg_encoder
    import hft_msg_pkg::*;
#(
    parameter int REG_WIDTH = 32,             // only 32 is supported
    parameter int MSG_WORDS = MSG_WORDS_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [1:0]           i_order_type,
    input  logic [1:0]           i_stock_symbol,
    input  logic [63:0]          i_order_id,
    input  logic [31:0]          i_price,
    input  logic [31:0]          i_quantity,
    input  logic                 i_trade_type,
    input  logic [47:0]          i_curr_time,
    input  logic [15:0]          i_locate_code,
    input  logic [15:0]          i_tracking_number,
    output logic [REG_WIDTH-1:0] o_word,
    output logic                 o_word_valid,
    input  logic                 i_word_ready,
    output logic [3:0]           o_word_index,
    output logic                 o_word_last,
    output logic                 o_err
);

    typedef enum logic {ST_IDLE = 1'b0, ST_SEND = 1'b1} state_t;

    localparam logic [3:0] LAST_IDX = 4'(MSG_WORDS - 1);

    state_t                              state_q, state_d;
    logic [3:0]                          idx_q, idx_d;
    logic [MSG_WORDS-1:0][REG_WIDTH-1:0] frame_q, frame_d;
    logic                                err_q, err_d;
    logic [PACK_WORDS-1:0][31:0]         packed_w;
    order_t                              ord_type;

    assign ord_type = order_t'(i_order_type);

    itch_msg_pack u_pack (
        .order_type_i (i_valid),
        .type_i       (ord_type),
        .stock_i      (stock_t'(i_stock_symbol)),
        .order_id_i   (i_order_id),
        .price_i      (i_price),
        .quantity_i   (i_quantity),
        .side_i       (trade_t'(i_trade_type)),
        .time_i       (i_curr_time),
        .locate_i     (i_locate_code),
        .tracking_i   (i_tracking_number),
        .words_o      (packed_w)
    );

`ifdef ITCH_MSG_CHECKSUM_EN
    logic [31:0] csum;

    // XOR of all packed words, captured with the frame
    always_comb begin
        csum = '0;
        for (int i = 0; i < PACK_WORDS; i++) csum = csum ^ packed_w[i];
    end
`endif

    // State, index, frame and error registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            frame_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            frame_q <= frame_d;
            err_q   <= err_d;
        end
    end

    // Accept in IDLE, stream in SEND; illegal orders are consumed and flagged
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        frame_d = frame_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    if (ord_type == ORD_ILLEGAL) begin
                        err_d = 1'b1;
                    end else begin
                        for (int i = 0; i < PACK_WORDS; i++) frame_d[i] = packed_w[i];
`ifdef ITCH_MSG_CHECKSUM_EN
                        frame_d[MSG_WORDS-1] = csum;
`endif
                        idx_d   = '0;
                        state_d = ST_SEND;
                    end
                end
            end
            ST_SEND: begin
                if (i_word_ready) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are pure decodes of registered state, so they hold under backpressure
    assign o_ready      = (state_q == ST_IDLE);
    assign o_word_valid = (state_q == ST_SEND);
    assign o_word       = o_word_valid ? frame_q[idx_q] : '0;
    assign o_word_index = idx_q;
    assign o_word_last  = o_word_valid && (idx_q == LAST_IDX);
    assign o_err        = err_q;

endmodule
